// File: rtl/reg_writeback_queue_pkg.sv
// ----------------------------------------------------------------------------
// PkgRegWriteback
// Shared types and constants for the register writeback queue.
//   WB_DEPTH       : port B FIFO entries (power of 2, >= 2)
//   WB_DATA_WIDTH  : register data width
//   WB_NUM_REGS    : architectural registers, register 0 hardwired to zero
//   WB_SEL_WIDTH   : register select width, the same width the register
//                    file uses for its write select
//   WbEntry        : one queued port B result {sel, data, kill}
//   PortIn_RegWriteback / PortOut_RegWriteback : bundled views of the
//                    queue's inputs and outputs, used inside the top module
// ----------------------------------------------------------------------------
package PkgRegWriteback;

  localparam int WB_DEPTH      = 4;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_NUM_REGS   = 16;
  localparam int WB_SEL_WIDTH  = 4;

  typedef struct packed {
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic [WB_DATA_WIDTH-1:0] data;
    logic                     kill;
  } WbEntry;

  typedef struct packed {
    logic                     aValid;
    logic [WB_SEL_WIDTH-1:0]  aSel;
    logic [WB_DATA_WIDTH-1:0] aData;
    logic                     bValid;
    logic [WB_SEL_WIDTH-1:0]  bSel;
    logic [WB_DATA_WIDTH-1:0] bData;
  } PortIn_RegWriteback;

  typedef struct packed {
    logic                     writeEn;
    logic [WB_SEL_WIDTH-1:0]  writeSel;
    logic [WB_DATA_WIDTH-1:0] writeData;
    logic [WB_NUM_REGS-1:0]   pending;
    logic                     empty;
    logic                     bReady;
  } PortOut_RegWriteback;

  // Register 0 is hardwired zero, so any traffic aimed at it is dropped.
  function automatic logic isLiveSel(input logic [WB_SEL_WIDTH-1:0] sel);
    return sel != '0;
  endfunction

endpackage

// File: rtl/reg_writeback_queue_fifo.sv
// ----------------------------------------------------------------------------
// reg_writeback_fifo
// Circular buffer holding port B results until the writeback port is free.
// Every entry compares its sel against the kill select in parallel so a
// newer port A write can cancel all older queued writes to the same register.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   i_push, i_pushSel,
//   i_pushData             : enqueue a live entry at the tail
//   i_pop                  : dequeue the head entry
//   i_killEn, i_killSel    : mark every stored entry with sel == i_killSel
//   o_headSel, o_headData,
//   o_headKill             : current head entry
//   o_full, o_empty        : occupancy flags from the registered count
// ----------------------------------------------------------------------------
module reg_writeback_fifo
  import PkgRegWriteback::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WB_SEL_WIDTH-1:0]  i_pushSel,
  input  logic [WB_DATA_WIDTH-1:0] i_pushData,
  input  logic                     i_pop,
  input  logic                     i_killEn,
  input  logic [WB_SEL_WIDTH-1:0]  i_killSel,
  output logic [WB_SEL_WIDTH-1:0]  o_headSel,
  output logic [WB_DATA_WIDTH-1:0] o_headData,
  output logic                     o_headKill,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  WbEntry           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign w_doPush   = i_push && !o_full;
  assign w_doPop    = i_pop && !o_empty;
  assign o_headSel  = r_mem[r_head].sel;
  assign o_headData = r_mem[r_head].data;
  assign o_headKill = r_mem[r_head].kill;

  // Storage and pointers. A slot being written by a push takes the fresh
  // entry with kill clear; this is what makes a same-cycle B push newer
  // than a same-cycle A write to the same register. Pointers wrap because
  // DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_doPush && (r_tail == PTR_W'(i))) begin
          r_mem[i] <= '{sel: i_pushSel, data: i_pushData, kill: 1'b0};
        end else if (i_killEn && (r_mem[i].sel == i_killSel)) begin
          r_mem[i].kill <= 1'b1;
        end
      end
      if (w_doPush) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_doPop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// ----------------------------------------------------------------------------
// reg_writeback_queue
// Sole writer of the register file write port. Merges single-cycle ALU
// results (port A, always accepted) with long-latency results (port B,
// valid/ready, buffered in a FIFO). Port A always wins arbitration; a port A
// write kills any older queued B write to the same register. A per-register
// pending mask lets decode stall on outstanding B writes.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   in_a_valid, in_a_sel, in_a_data     : ALU result
//   in_b_valid, in_b_ready, in_b_sel,
//   in_b_data                           : long-latency result handshake
//   out_write_en/_sel/_data             : registered register file write
//   out_pending                         : bit r set while a live B write to r
//                                         is queued
//   out_empty                           : FIFO holds no entries
// Optional build macro REG_WRITEBACK_QUEUE_STATS_EN adds:
//   out_stat_killed                     : killed entries popped (saturating)
//   out_stat_full_cycles                : cycles spent full (saturating)
// ----------------------------------------------------------------------------
module reg_writeback_queue
  import PkgRegWriteback::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NUM_REGS   = WB_NUM_REGS,
  parameter int SEL_WIDTH  = WB_SEL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_a_valid,
  input  logic [SEL_WIDTH-1:0]  in_a_sel,
  input  logic [DATA_WIDTH-1:0] in_a_data,
  input  logic                  in_b_valid,
  output logic                  in_b_ready,
  input  logic [SEL_WIDTH-1:0]  in_b_sel,
  input  logic [DATA_WIDTH-1:0] in_b_data,
  output logic                  out_write_en,
  output logic [SEL_WIDTH-1:0]  out_write_sel,
  output logic [DATA_WIDTH-1:0] out_write_data,
  output logic [NUM_REGS-1:0]   out_pending,
  output logic                  out_empty
`ifdef REG_WRITEBACK_QUEUE_STATS_EN
  ,
  output logic [31:0]           out_stat_killed,
  output logic [31:0]           out_stat_full_cycles
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  PortIn_RegWriteback  w_in;
  PortOut_RegWriteback w_out;

  logic                  w_aWrite;
  logic                  w_bAccept;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [SEL_WIDTH-1:0]  w_headSel;
  logic [DATA_WIDTH-1:0] w_headData;
  logic                  w_headKill;

  logic [CNT_W-1:0]      r_counter [NUM_REGS];
  logic [CNT_W-1:0]      w_cntNext [NUM_REGS];
  logic [NUM_REGS-1:0]   w_pending;

  logic                  r_writeEn;
  logic [SEL_WIDTH-1:0]  r_writeSel;
  logic [DATA_WIDTH-1:0] r_writeData;

  assign w_in.aValid = in_a_valid;
  assign w_in.aSel   = in_a_sel;
  assign w_in.aData  = in_a_data;
  assign w_in.bValid = in_b_valid;
  assign w_in.bSel   = in_b_sel;
  assign w_in.bData  = in_b_data;

  // Ready depends only on the registered full flag, so a full queue never
  // accepts even when it pops the same cycle.
  assign w_aWrite  = w_in.aValid && isLiveSel(w_in.aSel);
  assign w_bAccept = w_in.bValid && !w_full && isLiveSel(w_in.bSel);
  assign w_pop     = !w_aWrite && !w_empty;

  reg_writeback_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_bAccept),
    .i_pushSel (w_in.bSel),
    .i_pushData(w_in.bData),
    .i_pop     (w_pop),
    .i_killEn  (w_aWrite),
    .i_killSel (w_in.aSel),
    .o_headSel (w_headSel),
    .o_headData(w_headData),
    .o_headKill(w_headKill),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Per-register count of live queued B writes. Order matters: the pop
  // decrement and A-write clear happen first, then a same-cycle B push
  // increments, so A and B to the same register in one cycle leaves 1.
  // Killed entries were already removed from the count when A cleared it.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cntNext[r] = r_counter[r];
      if (w_pop && !w_headKill && (w_headSel == SEL_WIDTH'(r)) && (r_counter[r] != '0)) begin
        w_cntNext[r] = r_counter[r] - 1'b1;
      end
      if (w_aWrite && (w_in.aSel == SEL_WIDTH'(r))) begin
        w_cntNext[r] = '0;
      end
      if (w_bAccept && (w_in.bSel == SEL_WIDTH'(r))) begin
        w_cntNext[r] = w_cntNext[r] + 1'b1;
      end
    end
  end

  // Pending bits come straight from the registered counters; register 0 is
  // forced low since it can never be written.
  always_comb begin
    w_pending = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_pending[r] = (r_counter[r] != '0);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_counter[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_counter[r] <= w_cntNext[r];
      end
    end
  end

  // Registered write port. A always wins; otherwise the head is popped and
  // written unless it was killed. Select and data hold whenever no write
  // is issued, including a killed pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_writeEn   <= 1'b0;
      r_writeSel  <= '0;
      r_writeData <= '0;
    end else if (w_aWrite) begin
      r_writeEn   <= 1'b1;
      r_writeSel  <= w_in.aSel;
      r_writeData <= w_in.aData;
    end else if (w_pop && !w_headKill) begin
      r_writeEn   <= 1'b1;
      r_writeSel  <= w_headSel;
      r_writeData <= w_headData;
    end else begin
      r_writeEn   <= 1'b0;
    end
  end

  assign w_out.writeEn   = r_writeEn;
  assign w_out.writeSel  = r_writeSel;
  assign w_out.writeData = r_writeData;
  assign w_out.pending   = w_pending;
  assign w_out.empty     = w_empty;
  assign w_out.bReady    = !w_full;

  assign out_write_en   = w_out.writeEn;
  assign out_write_sel  = w_out.writeSel;
  assign out_write_data = w_out.writeData;
  assign out_pending    = w_out.pending;
  assign out_empty      = w_out.empty;
  assign in_b_ready     = w_out.bReady;

`ifdef REG_WRITEBACK_QUEUE_STATS_EN
  logic [31:0] r_statKilled;
  logic [31:0] r_statFull;

  // Saturating event counters for killed pops and cycles spent full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_statKilled <= '0;
      r_statFull   <= '0;
    end else begin
      if (w_pop && w_headKill && (r_statKilled != '1)) begin
        r_statKilled <= r_statKilled + 1'b1;
      end
      if (w_full && (r_statFull != '1)) begin
        r_statFull <= r_statFull + 1'b1;
      end
    end
  end

  assign out_stat_killed      = r_statKilled;
  assign out_stat_full_cycles = r_statFull;
`else
  // Statistics are not built; nothing else depends on them.
`endif

endmodule
